// File: rtl/inst_fetch_if.sv
// Fetch sequencer bus: harness/decoder controls in, ROM address and status out.
interface inst_fetch_if #(
    parameter int A = 10,
    parameter int O = 6,
    parameter int C = 16
);
    logic         Start;
    logic [A-1:0] StartAddr;
    logic         Halt;
    logic         Stall;
    logic         Jump;
    logic [A-1:0] Target;
    logic         BranchTaken;
    logic [O-1:0] Offset;
    logic         Call;
    logic         Ret;
    logic [A-1:0] InstAddress;
    logic         Running;
    logic         Done;
    logic [C-1:0] InstCount;

    modport slave (
        input  Start, StartAddr, Halt, Stall, Jump, Target,
        input  BranchTaken, Offset, Call, Ret,
        output InstAddress, Running, Done, InstCount
    );

    modport master (
        output Start, StartAddr, Halt, Stall, Jump, Target,
        output BranchTaken, Offset, Call, Ret,
        input  InstAddress, Running, Done, InstCount
    );
endinterface

// File: rtl/inst_fetch.sv
// PC / fetch sequencer with Start/Done handshake and saturating retire count.
// Optional single-entry call/return link when FETCH_LINK_EN is defined.
module inst_fetch #(
    parameter int A = 10,
    parameter int O = 6,
    parameter int C = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    inst_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [C-1:0] cnt_q, cnt_d;
    logic         running_q, done_q;
    logic [C-1:0] cnt_inc;
    logic [A-1:0] pc_seq;
    logic [A-1:0] pc_br;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + C'(1);
    assign pc_seq  = pc_q + A'(1);
    assign pc_br   = pc_q + {{(A-O){bus.Offset[O-1]}}, bus.Offset};

`ifdef FETCH_LINK_EN
    logic [A-1:0] link_q, link_d;
`else
    logic unused_link;
    assign unused_link = ^{bus.Call, bus.Ret};
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef FETCH_LINK_EN
        link_d  = link_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    pc_d    = bus.StartAddr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                priority case (1'b1)
                    bus.Halt: state_d = DONE;
                    bus.Stall: cnt_d = cnt_q;
`ifdef FETCH_LINK_EN
                    bus.Ret: pc_d = link_q;
                    bus.Call: begin
                        link_d = pc_seq;
                        pc_d   = bus.Target;
                    end
`endif
                    bus.Jump: pc_d = bus.Target;
                    bus.BranchTaken: pc_d = pc_br;
                    default: pc_d = pc_seq;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef FETCH_LINK_EN
            link_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == RUN);
            done_q    <= (state_d == DONE);
`ifdef FETCH_LINK_EN
            link_q    <= link_d;
`endif
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.Running     = running_q;
    assign bus.Done        = done_q;
    assign bus.InstCount   = cnt_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed steps push expectations,
// a monitor pops one per clock edge and compares both instances.
module tb_inst_fetch;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    always #5 Clk = ~Clk;

    inst_fetch_if #(.A(10), .O(6), .C(16)) m_if ();
    inst_fetch_if #(.A(10), .O(6), .C(4))  s_if ();

    inst_fetch #(.A(10), .O(6), .C(16)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(m_if.slave)
    );
    inst_fetch #(.A(10), .O(6), .C(4)) u_sat (
        .Clk(Clk), .Reset_n(Reset_n), .bus(s_if.slave)
    );

    typedef struct {
        string      nm;
        bit         sat;
        logic [9:0] pc;
        bit         run;
        bit         dn;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(posedge Clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.sat) begin
                chk({e.nm, ".pc"}, int'(s_if.InstAddress), int'(e.pc));
                chk({e.nm, ".run"}, int'(s_if.Running), int'(e.run));
                chk({e.nm, ".done"}, int'(s_if.Done), int'(e.dn));
                chk({e.nm, ".cnt"}, int'(s_if.InstCount), e.cnt);
            end else begin
                chk({e.nm, ".pc"}, int'(m_if.InstAddress), int'(e.pc));
                chk({e.nm, ".run"}, int'(m_if.Running), int'(e.run));
                chk({e.nm, ".done"}, int'(m_if.Done), int'(e.dn));
                chk({e.nm, ".cnt"}, int'(m_if.InstCount), e.cnt);
            end
        end
    end

    task automatic clr();
        m_if.Start = 0; m_if.StartAddr = '0; m_if.Halt = 0;
        m_if.Stall = 0; m_if.Jump = 0; m_if.Target = '0;
        m_if.BranchTaken = 0; m_if.Offset = '0;
        m_if.Call = 0; m_if.Ret = 0;
        s_if.Start = 0; s_if.StartAddr = '0; s_if.Halt = 0;
        s_if.Stall = 0; s_if.Jump = 0; s_if.Target = '0;
        s_if.BranchTaken = 0; s_if.Offset = '0;
        s_if.Call = 0; s_if.Ret = 0;
    endtask

    task automatic step(string nm, logic [9:0] pc, bit run,
                        bit dn, int cnt, bit sat = 1'b0);
        exp_t e;
        e.nm = nm; e.sat = sat; e.pc = pc;
        e.run = run; e.dn = dn; e.cnt = cnt;
        exp_q.push_back(e);
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, ".pc"}, int'(m_if.InstAddress), 0);
        chk({nm, ".run"}, int'(m_if.Running), 0);
        chk({nm, ".done"}, int'(m_if.Done), 0);
        chk({nm, ".cnt"}, int'(m_if.InstCount), 0);
    endtask

    initial begin
        int waited;
        clr();
        @(negedge Clk);
        chk_zero("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // start and sequential fetch
        clr(); m_if.Start = 1; m_if.StartAddr = 10'h010;
        step("start", 10'h010, 1, 0, 0);
        clr(); step("seq1", 10'h011, 1, 0, 1);
        step("seq2", 10'h012, 1, 0, 2);

        // asynchronous abort mid-RUN
        #2 Reset_n = 1'b0;
        #1 chk_zero("async_rst");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // relative branches, including wrap below zero
        clr(); m_if.Start = 1; m_if.StartAddr = 10'h020;
        step("start2", 10'h020, 1, 0, 0);
        clr(); m_if.BranchTaken = 1; m_if.Offset = 6'h3E;
        step("br_m2", 10'h01E, 1, 0, 1);
        clr(); m_if.Jump = 1; m_if.Target = 10'h000;
        step("jmp0", 10'h000, 1, 0, 2);
        clr(); m_if.BranchTaken = 1; m_if.Offset = 6'h3F;
        step("br_wrap", 10'h3FF, 1, 0, 3);
        clr(); step("seq_wrap", 10'h000, 1, 0, 4);

        // priority
        clr(); m_if.Jump = 1; m_if.Target = 10'h100;
        m_if.BranchTaken = 1; m_if.Offset = 6'h01;
        step("jmp_over_br", 10'h100, 1, 0, 5);
        clr(); m_if.Stall = 1; m_if.Jump = 1; m_if.Target = 10'h2AA;
        step("stall_hold", 10'h100, 1, 0, 5);
        clr(); m_if.Halt = 1; m_if.Jump = 1; m_if.Target = 10'h155;
        step("halt_over_jmp", 10'h100, 0, 1, 6);

        // halt after 6 retired, DONE ignores controls, restart
        clr(); m_if.Start = 1; m_if.StartAddr = 10'h3FF;
        step("restart", 10'h3FF, 1, 0, 0);
        clr(); step("r1", 10'h000, 1, 0, 1);
        step("r2", 10'h001, 1, 0, 2);
        step("r3", 10'h002, 1, 0, 3);
        step("r4", 10'h003, 1, 0, 4);
        step("r5", 10'h004, 1, 0, 5);
        step("r6", 10'h005, 1, 0, 6);
        clr(); m_if.Halt = 1;
        step("halt5", 10'h005, 0, 1, 7);
        clr(); m_if.Jump = 1; m_if.Target = 10'h123;
        step("done_jmp", 10'h005, 0, 1, 7);
        clr(); m_if.Start = 1; m_if.StartAddr = 10'h0AB;
        m_if.Halt = 1;
        step("done_start", 10'h0AB, 1, 0, 0);
        clr(); m_if.Start = 1; m_if.StartAddr = 10'h300;
        step("run_start_ign", 10'h0AC, 1, 0, 1);

        // call / return
        clr(); m_if.Jump = 1; m_if.Target = 10'h040;
        step("jmp40", 10'h040, 1, 0, 2);
        clr(); m_if.Call = 1; m_if.Target = 10'h200;
`ifdef FETCH_LINK_EN
        step("call", 10'h200, 1, 0, 3);
        clr(); m_if.Ret = 1;
        step("ret", 10'h041, 1, 0, 4);
        clr(); m_if.Call = 1; m_if.Ret = 1; m_if.Target = 10'h300;
        step("call_ret", 10'h041, 1, 0, 5);
`else
        step("call_ign", 10'h041, 1, 0, 3);
        clr(); m_if.Ret = 1;
        step("ret_ign", 10'h042, 1, 0, 4);
        clr(); m_if.Call = 1; m_if.Ret = 1; m_if.Target = 10'h300;
        step("call_ret_ign", 10'h043, 1, 0, 5);
`endif

        // saturation on the 4-bit counter instance
        clr(); s_if.Start = 1; s_if.StartAddr = 10'h000;
        step("sat_start", 10'h000, 1, 0, 0, 1'b1);
        clr();
        for (int n = 1; n <= 20; n++)
            step("sat", 10'(n), 1, 0, (n > 15) ? 15 : n, 1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
